// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between fetch (IF) and the memory stage (MEM); read data returns 1 cycle after grant.
// The loser stalls (Req && !Grant); i_Bus_Ready=0 stalls both. Optional perf counters under `MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_IF_Req,
  input  logic [31:0] i_IF_Address,
  output logic        o_IF_Grant,
  output logic        o_IF_RespValid,
  output logic [31:0] o_IF_RespData,
  input  logic        i_MEM_Read,
  input  logic        i_MEM_Write,
  input  logic [1:0]  i_MEM_Mode,
  input  logic [31:0] i_MEM_Address,
  input  logic [31:0] i_MEM_WriteData,
  output logic        o_MEM_Grant,
  output logic        o_MEM_RespValid,
  output logic [31:0] o_MEM_RespData,
  output logic        o_Bus_ReadEnable,
  output logic        o_Bus_WriteEnable,
  output logic [1:0]  o_Bus_Mode,
  output logic [31:0] o_Bus_Address,
  output logic [31:0] o_Bus_WriteData,
  input  logic [31:0] i_Bus_ReadData,
  input  logic        i_Bus_Ready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] o_PerfIfStallCycles,
  output logic [31:0] o_PerfMemStallCycles,
  output logic [31:0] o_PerfGrants
`endif
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_MEM = 2'd2} owner_e;

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       mem_req;
  logic       if_gnt;
  logic       mem_gnt;

  assign mem_req = i_MEM_Read | i_MEM_Write;

  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (i_Reset_n && i_Bus_Ready) begin
      // MEM wins ties unless fetch has been starved long enough
      if (i_IF_Req && (!mem_req || starve_q >= 4'(MAX_STARVE))) begin
        if_gnt = 1'b1;
      end else if (mem_req) begin
        mem_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_IF_Req || if_gnt) begin
      starve_d = 4'd0;
    end else if (i_Bus_Ready && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (mem_gnt && !i_MEM_Write) begin
      owner_d = OWN_MEM;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    o_IF_Grant        = if_gnt;
    o_MEM_Grant       = mem_gnt;
    o_Bus_ReadEnable  = 1'b0;
    o_Bus_WriteEnable = 1'b0;
    o_Bus_Mode        = 2'b00;
    o_Bus_Address     = 32'd0;
    o_Bus_WriteData   = 32'd0;
    if (if_gnt) begin
      o_Bus_ReadEnable = 1'b1;
      o_Bus_Mode       = 2'b10;
      o_Bus_Address    = i_IF_Address;
    end else if (mem_gnt) begin
      // Read and write together is illegal; the write takes precedence
      o_Bus_ReadEnable  = i_MEM_Read & ~i_MEM_Write;
      o_Bus_WriteEnable = i_MEM_Write;
      o_Bus_Mode        = i_MEM_Mode;
      o_Bus_Address     = i_MEM_Address;
      o_Bus_WriteData   = i_MEM_WriteData;
    end
  end

  always_comb begin
    o_IF_RespValid  = i_Reset_n && (owner_q == OWN_IF);
    o_MEM_RespValid = i_Reset_n && (owner_q == OWN_MEM);
    o_IF_RespData   = o_IF_RespValid  ? i_Bus_ReadData : 32'd0;
    o_MEM_RespData  = o_MEM_RespValid ? i_Bus_ReadData : 32'd0;
  end

  mem_rw_exclusive: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    !(i_MEM_Read && i_MEM_Write));

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall_q, perf_if_stall_d;
  logic [31:0] perf_mem_stall_q, perf_mem_stall_d;
  logic [31:0] perf_grants_q, perf_grants_d;

  always_comb begin
    perf_if_stall_d  = perf_if_stall_q  + {31'd0, i_IF_Req & ~if_gnt};
    perf_mem_stall_d = perf_mem_stall_q + {31'd0, mem_req & ~mem_gnt};
    perf_grants_d    = perf_grants_q    + {31'd0, if_gnt | mem_gnt};
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      perf_if_stall_q  <= 32'd0;
      perf_mem_stall_q <= 32'd0;
      perf_grants_q    <= 32'd0;
    end else begin
      perf_if_stall_q  <= perf_if_stall_d;
      perf_mem_stall_q <= perf_mem_stall_d;
      perf_grants_q    <= perf_grants_d;
    end
  end

  assign o_PerfIfStallCycles  = perf_if_stall_q;
  assign o_PerfMemStallCycles = perf_mem_stall_q;
  assign o_PerfGrants         = perf_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected read responses are queued at grant time and popped one cycle later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rv;
  logic [31:0] if_rdata;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rv;
  logic [31:0] mem_rdata;
  logic        bus_re, bus_we;
  logic [1:0]  bus_mode;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdat = 32'd0;
  logic        bus_rdy;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } resp_t;

  resp_t expq[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_STARVE(4)) dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_IF_Req         (if_req),
    .i_IF_Address     (if_addr),
    .o_IF_Grant       (if_gnt),
    .o_IF_RespValid   (if_rv),
    .o_IF_RespData    (if_rdata),
    .i_MEM_Read       (mem_rd),
    .i_MEM_Write      (mem_wr),
    .i_MEM_Mode       (mem_mode),
    .i_MEM_Address    (mem_addr),
    .i_MEM_WriteData  (mem_wdata),
    .o_MEM_Grant      (mem_gnt),
    .o_MEM_RespValid  (mem_rv),
    .o_MEM_RespData   (mem_rdata),
    .o_Bus_ReadEnable (bus_re),
    .o_Bus_WriteEnable(bus_we),
    .o_Bus_Mode       (bus_mode),
    .o_Bus_Address    (bus_addr),
    .o_Bus_WriteData  (bus_wdata),
    .i_Bus_ReadData   (bus_rdat),
    .i_Bus_Ready      (bus_rdy)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'd3) ^ 32'h5A5A0000;
  endfunction

  // Synchronous memory: data for a read-enable cycle appears the following cycle
  always @(posedge clk) begin
    if (bus_re) bus_rdat <= memf(bus_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    resp_t r;
    if (!rst_n) begin
      expq.delete();
      chk("if_rv_in_reset", {31'd0, if_rv}, 32'd0);
      chk("mem_rv_in_reset", {31'd0, mem_rv}, 32'd0);
    end else if (expq.size() > 0) begin
      r = expq.pop_front();
      chk("if_rv", {31'd0, if_rv}, {31'd0, r.is_if});
      chk("mem_rv", {31'd0, mem_rv}, {31'd0, !r.is_if});
      if (r.is_if) begin
        chk("if_rdata", if_rdata, r.data);
        chk("mem_rdata_idle", mem_rdata, 32'd0);
      end else begin
        chk("mem_rdata", mem_rdata, r.data);
        chk("if_rdata_idle", if_rdata, 32'd0);
      end
    end else begin
      chk("if_rv_none", {31'd0, if_rv}, 32'd0);
      chk("mem_rv_none", {31'd0, mem_rv}, 32'd0);
    end
  endtask

  task automatic sample(input logic eg_if, input logic eg_mem);
    resp_t r;
    @(negedge clk);
    check_resp();
    chk("if_grant", {31'd0, if_gnt}, {31'd0, eg_if});
    chk("mem_grant", {31'd0, mem_gnt}, {31'd0, eg_mem});
    if (eg_if) begin
      r.is_if = 1'b1;
      r.data  = memf(if_addr);
      expq.push_back(r);
    end
    if (eg_mem && mem_rd && !mem_wr) begin
      r.is_if = 1'b0;
      r.data  = memf(mem_addr);
      expq.push_back(r);
    end
    if (!eg_if && !eg_mem) begin
      chk("bus_re_idle", {31'd0, bus_re}, 32'd0);
      chk("bus_we_idle", {31'd0, bus_we}, 32'd0);
      chk("bus_addr_idle", bus_addr, 32'd0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic eg_if, input logic eg_mem);
    sample(eg_if, eg_mem);
    advance();
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_mode  = 2'b00;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    bus_rdy   = 1'b1;

    // Reset held two cycles with fetch requesting
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;

    // First cycle out of reset: fetch of 0x100 granted, word read on the bus
    sample(1'b1, 1'b0);
    chk("if_bus_re", {31'd0, bus_re}, 32'd1);
    chk("if_bus_we", {31'd0, bus_we}, 32'd0);
    chk("if_bus_mode", {30'd0, bus_mode}, 32'd2);
    chk("if_bus_addr", bus_addr, 32'h100);
    chk("if_bus_wdata", bus_wdata, 32'd0);
    advance();
    if_req = 1'b0;
    cyc(1'b0, 1'b0);

    // Contention: MEM four times, then starved fetch, then MEM again from a cleared count
    if_req   = 1'b1;
    if_addr  = 32'h200;
    mem_rd   = 1'b1;
    mem_mode = 2'b00;
    mem_addr = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      sample(i == 4 || i == 9, !(i == 4 || i == 9));
      if (i == 0) begin
        chk("mem_bus_mode", {30'd0, bus_mode}, 32'd0);
        chk("mem_bus_addr", bus_addr, 32'h2000);
      end
      advance();
    end

    // Word store: no response afterwards
    if_req    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b1;
    mem_mode  = 2'b10;
    mem_addr  = 32'h40;
    mem_wdata = 32'h12345678;
    sample(1'b0, 1'b1);
    chk("st_bus_we", {31'd0, bus_we}, 32'd1);
    chk("st_bus_re", {31'd0, bus_re}, 32'd0);
    chk("st_bus_addr", bus_addr, 32'h40);
    chk("st_bus_wdata", bus_wdata, 32'h12345678);
    chk("st_bus_mode", {30'd0, bus_mode}, 32'd2);
    advance();
    mem_wr = 1'b0;
    cyc(1'b0, 1'b0);

    // Build starve count to 2, hold it across 3 not-ready cycles, then fetch wins on the third ready grant
    if_req   = 1'b1;
    if_addr  = 32'h300;
    mem_rd   = 1'b1;
    mem_addr = 32'h2004;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    bus_rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    bus_rdy = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);

    // Reset right after a fetch grant drops the response
    mem_rd  = 1'b0;
    if_addr = 32'h310;
    cyc(1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n  = 1'b1;
    if_req = 1'b0;
    cyc(1'b0, 1'b0);
    if_req = 1'b1;
    cyc(1'b1, 1'b0);
    if_req = 1'b0;
    cyc(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between instruction fetch (IF, read-only, word) and the memory stage (MEM, byte/half/word read or write).
- Sits between the fetch stage/memory stage and the unified memory bus.
- Grants at most one request per cycle and returns read data to the owner one cycle later.
- Issues stalls to the losing requester; an anti-starvation counter guarantees forward progress for fetch.

Parameters:
- MAX_STARVE, 4: consecutive cycles IF may be denied before it gets priority for one grant; legal range 1..15.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  synchronous active-low reset
- i_IF_Req  in  1  fetch read request
- i_IF_Address  in  32  fetch address, word-aligned
- o_IF_Grant  out  1  IF request accepted this cycle
- o_IF_RespValid  out  1  o_IF_RespData valid
- o_IF_RespData  out  32  fetched word
- i_MEM_Read  in  1  memory-stage load request
- i_MEM_Write  in  1  memory-stage store request
- i_MEM_Mode  in  2  00 byte, 01 half, 10 word
- i_MEM_Address  in  32  load/store address
- i_MEM_WriteData  in  32  store data
- o_MEM_Grant  out  1  MEM request accepted this cycle
- o_MEM_RespValid  out  1  o_MEM_RespData valid (loads only)
- o_MEM_RespData  out  32  load data
- o_Bus_ReadEnable  out  1  to memory
- o_Bus_WriteEnable  out  1  to memory
- o_Bus_Mode  out  2  to memory
- o_Bus_Address  out  32  to memory
- o_Bus_WriteData  out  32  to memory
- i_Bus_ReadData  in  32  read data, valid 1 cycle after a read-enable cycle
- i_Bus_Ready  in  1  memory can accept a request this cycle

Behaviour:
- Interface: one clock i_Clock; reset i_Reset_n is synchronous and active-low.
- Reset (i_Reset_n=0 at a rising edge) clears: owner tag=NONE, starve count=0, both RespValid=0.
- While i_Reset_n=0, both Grants=0 and bus enables=0.
- Grants, bus outputs and stalls are combinational from the current-cycle requests and registered state. Stall = Req && !Grant.
- MEM request = i_MEM_Read | i_MEM_Write. Both asserted together is illegal: treat as write, and flag with an assertion in simulation.
- i_Bus_Ready=0: no grant, bus enables 0, starve count holds.
- Priority with both requesting and ready:
  - MEM wins by default.
  - IF wins if starve count ≥ MAX_STARVE.
- Starve count (4-bit, saturating at 15):
  - increments when i_IF_Req && !o_IF_Grant && i_Bus_Ready;
  - clears on IF grant or when !i_IF_Req.
- Single requester with ready: always granted.
- Bus mux:
  - IF grant: ReadEnable=1, Mode=10, Address=i_IF_Address, WriteData=0.
  - MEM grant: passes i_MEM_* fields.
  - No grant: all outputs 0.
- Response pipeline: owner tag register (NONE/IF/MEM) is set at the edge after a granted read (IF or MEM load); stores set NONE.
  - Next cycle, the owner's RespValid=1 and its RespData=i_Bus_ReadData.
  - The other port's RespData=0 and RespValid=0.
  - Latency from grant to RespValid: exactly 1 cycle.
- Back-to-back grants are allowed every cycle. A new grant overwrites the tag while the previous response is presented that cycle.
- Reset asserted while a read is outstanding: response is dropped (RespValid=0 next cycle).

Optional Feature:
- MEM_ARB_PERF_EN: adds outputs o_PerfIfStallCycles[31:0], o_PerfMemStallCycles[31:0] and o_PerfGrants[31:0].
  - Each counter increments on its respective event, wraps at 2^32, and clears on reset.
- Without the macro, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles with i_IF_Req=1 -> Grants=0, bus enables=0, RespValid=0. After release, IF granted on the first cycle.
- IF-only read at 0x100, memory returns 0xDEADBEEF -> o_IF_Grant=1 in cycle N; o_IF_RespValid=1 with data 0xDEADBEEF in N+1; o_MEM_RespValid=0.
- IF and MEM load (0x2000, mode 00) together, MAX_STARVE=4 -> MEM granted cycles 0-3, IF granted cycle 4, starve count back to 0 in cycle 5.
- MEM store 0x12345678 to 0x40 mode 10 -> bus WriteEnable=1 with matching address/data; no RespValid on either port the next cycle.
- i_Bus_Ready=0 for 3 cycles with both requesting -> no grants, starve count unchanged. On ready=1, MEM granted.
- IF read granted, reset asserted the next cycle -> o_IF_RespValid stays 0; owner tag NONE after reset.
